// File: rtl/mod_74x161_cascade.sv
// mod_74x161_cascade
//   A chain of STAGES synchronous 4-bit binary counters, each behaving like a
//   74x161.  The ripple carry of one stage feeds the T enable of the next, so
//   the chain counts as one 4*STAGES-bit binary counter.
//
// Ports
//   CLK      rising-edge clock for load and count
//   CLR_N    asynchronous active-low clear of every stage
//   LOAD_N   synchronous active-low parallel load; it has priority over counting
//   ENP      count enable P, shared by every stage; it never affects a carry
//   ENT      count enable T into stage 1; it also gates every carry
//   D        parallel load data, big-endian: D[4*STAGES-1] is the LSB
//   Q        count value, big-endian: Q[4*STAGES-1] is the LSB
//   RCO_STG  per-stage ripple carry; RCO_STG[STAGES-1] belongs to stage 1
//   RCO      ripple carry out of the most significant stage
//
// STAGES must be in the range 1..8.

module mod_74x161_cascade #(
    parameter int STAGES = 3
) (
    input  logic                  CLK,
    input  logic                  CLR_N,
    input  logic                  LOAD_N,
    input  logic                  ENP,
    input  logic                  ENT,
    input  logic [0:4*STAGES-1]   D,
    output logic [0:4*STAGES-1]   Q,
    output logic [0:STAGES-1]     RCO_STG,
    output logic                  RCO
);

    // g_stage[gi] is stage gi+1; gi = 0 is the least significant nibble.
    // Because the ports are declared big-endian, stage gi+1 occupies the
    // 4-bit slice starting at index 4*(STAGES-1-gi), with its MSB at the
    // lowest index of that slice.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [3:0] nibble_reg;
            logic [3:0] nibble_next;
            logic [3:0] load_val;
            logic       ent_in;
            logic       rco;

            if (gi == 0) begin : g_first
                assign ent_in = ENT;
            end else begin : g_chain
                // T enable of a higher stage is the carry of the stage below,
                // which already folds in ENT and every lower nibble being F.
                assign ent_in = g_stage[gi-1].rco;
            end

            assign load_val = D[4*(STAGES-1-gi) +: 4];
            assign rco      = ent_in & (nibble_reg == 4'hF);

            always_comb begin
                nibble_next = nibble_reg;
                if (!LOAD_N) begin
                    nibble_next = load_val;
                end else if (ENP && ent_in) begin
                    nibble_next = nibble_reg + 4'd1;
                end
            end

            always_ff @(posedge CLK or negedge CLR_N) begin
                if (!CLR_N) begin
                    nibble_reg <= 4'h0;
                end else begin
                    nibble_reg <= nibble_next;
                end
            end

            assign Q[4*(STAGES-1-gi) +: 4] = nibble_reg;
            assign RCO_STG[STAGES-1-gi]    = rco;
        end
    endgenerate

    assign RCO = g_stage[STAGES-1].rco;

endmodule

// File: tb/tb_mod_74x161_cascade.sv
// Testbench for mod_74x161_cascade: a 3-stage instance for the directed
// scenarios and a 1-stage instance for the single-nibble wrap.  Expected
// values are pushed to a scoreboard queue when the stimulus is applied and
// popped when the DUT output is sampled (1 time unit after the clock edge or
// after a combinational input change).

module tb_mod_74x161_cascade;

    typedef struct {
        logic [11:0] q;
        logic [2:0]  stg;
        logic        rco;
    } exp_t;

    typedef struct {
        logic        load_n;
        logic        enp;
        logic        ent;
        logic [11:0] d;
        logic        edge_step;   // 1: clock one edge, 0: combinational check only
        logic [11:0] q;
        logic [2:0]  stg;
        logic        rco;
    } row_t;

    logic        clk;
    logic        clr_n;
    logic        load_n;
    logic        enp;
    logic        ent;
    logic [11:0] d;
    logic [11:0] q;
    logic [2:0]  rco_stg;
    logic        rco;

    logic        load_n1;
    logic        enp1;
    logic        ent1;
    logic [3:0]  d1;
    logic [3:0]  q1;
    logic [0:0]  rco_stg1;
    logic        rco1;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mod_74x161_cascade #(.STAGES(3)) dut3 (
        .CLK     (clk),
        .CLR_N   (clr_n),
        .LOAD_N  (load_n),
        .ENP     (enp),
        .ENT     (ent),
        .D       (d),
        .Q       (q),
        .RCO_STG (rco_stg),
        .RCO     (rco)
    );

    mod_74x161_cascade #(.STAGES(1)) dut1 (
        .CLK     (clk),
        .CLR_N   (clr_n),
        .LOAD_N  (load_n1),
        .ENP     (enp1),
        .ENT     (ent1),
        .D       (d1),
        .Q       (q1),
        .RCO_STG (rco_stg1),
        .RCO     (rco1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
        $fatal(1, "watchdog");
    end

    // Clear held across two edges that would otherwise load, then release and count.
    task automatic test_reset();
        exp_t e;
        logic [11:0] cnt_exp [3] = '{12'h001, 12'h002, 12'h003};
        clr_n = 1'b0; load_n = 1'b0; enp = 1'b1; ent = 1'b1; d = 12'hABC;
        load_n1 = 1'b0; enp1 = 1'b1; ent1 = 1'b1; d1 = 4'h9;
        sb.push_back('{q: 12'h000, stg: 3'b000, rco: 1'b0});
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        checks += 4;
        if (q !== e.q) begin errors++; $display("FAIL reset_q: got %h required %h", q, e.q); end
        if (rco_stg !== e.stg) begin errors++; $display("FAIL reset_stg: got %b required %b", rco_stg, e.stg); end
        if (rco !== e.rco) begin errors++; $display("FAIL reset_rco: got %b required %b", rco, e.rco); end
        if (q1 !== 4'h0) begin errors++; $display("FAIL reset_q1: got %h required 0", q1); end
        $display("reset held: q=%h stg=%b rco=%b q1=%h", q, rco_stg, rco, q1);
        #3 clr_n = 1'b1;
        load_n = 1'b1; load_n1 = 1'b1; enp1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{q: cnt_exp[i], stg: 3'b000, rco: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (q !== e.q) begin errors++; $display("FAIL resume_q[%0d]: got %h required %h", i, q, e.q); end
            if (rco_stg !== e.stg) begin errors++; $display("FAIL resume_stg[%0d]: got %b required %b", i, rco_stg, e.stg); end
            if (rco !== e.rco) begin errors++; $display("FAIL resume_rco[%0d]: got %b required %b", i, rco, e.rco); end
            $display("resume edge %0d: q=%h stg=%b rco=%b", i, q, rco_stg, rco);
        end
    endtask

    task automatic test_load_count();
        exp_t e;
        row_t rows [3] = '{
            '{1'b0, 1'b1, 1'b1, 12'h00E, 1'b1, 12'h00E, 3'b000, 1'b0},
            '{1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'h00F, 3'b001, 1'b0},
            '{1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'h010, 3'b000, 1'b0}
        };
        for (int i = 0; i < 3; i++) begin
            load_n = rows[i].load_n; enp = rows[i].enp; ent = rows[i].ent; d = rows[i].d;
            sb.push_back('{q: rows[i].q, stg: rows[i].stg, rco: rows[i].rco});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (q !== e.q) begin errors++; $display("FAIL load_count_q[%0d]: got %h required %h", i, q, e.q); end
            if (rco_stg !== e.stg) begin errors++; $display("FAIL load_count_stg[%0d]: got %b required %b", i, rco_stg, e.stg); end
            if (rco !== e.rco) begin errors++; $display("FAIL load_count_rco[%0d]: got %b required %b", i, rco, e.rco); end
            $display("load_count %0d: q=%h stg=%b rco=%b", i, q, rco_stg, rco);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        row_t rows [3] = '{
            '{1'b0, 1'b1, 1'b1, 12'hFFE, 1'b1, 12'hFFE, 3'b000, 1'b0},
            '{1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'hFFF, 3'b111, 1'b1},
            '{1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'h000, 3'b000, 1'b0}
        };
        for (int i = 0; i < 3; i++) begin
            load_n = rows[i].load_n; enp = rows[i].enp; ent = rows[i].ent; d = rows[i].d;
            sb.push_back('{q: rows[i].q, stg: rows[i].stg, rco: rows[i].rco});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (q !== e.q) begin errors++; $display("FAIL wrap_q[%0d]: got %h required %h", i, q, e.q); end
            if (rco_stg !== e.stg) begin errors++; $display("FAIL wrap_stg[%0d]: got %b required %b", i, rco_stg, e.stg); end
            if (rco !== e.rco) begin errors++; $display("FAIL wrap_rco[%0d]: got %b required %b", i, rco, e.rco); end
            $display("wrap %0d: q=%h stg=%b rco=%b", i, q, rco_stg, rco);
        end
    endtask

    // Hold at 0FF: ENT low kills every carry; ENP low keeps carries but holds Q.
    task automatic test_hold();
        exp_t e;
        row_t rows [5] = '{
            '{1'b0, 1'b1, 1'b1, 12'h0FF, 1'b1, 12'h0FF, 3'b011, 1'b0},
            '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h0FF, 3'b000, 1'b0},
            '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h0FF, 3'b000, 1'b0},
            '{1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 12'h0FF, 3'b011, 1'b0},
            '{1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 12'h0FF, 3'b011, 1'b0}
        };
        for (int i = 0; i < 5; i++) begin
            load_n = rows[i].load_n; enp = rows[i].enp; ent = rows[i].ent; d = rows[i].d;
            sb.push_back('{q: rows[i].q, stg: rows[i].stg, rco: rows[i].rco});
            if (rows[i].edge_step) @(posedge clk);
            #1;
            e = sb.pop_front();
            checks += 3;
            if (q !== e.q) begin errors++; $display("FAIL hold_q[%0d]: got %h required %h", i, q, e.q); end
            if (rco_stg !== e.stg) begin errors++; $display("FAIL hold_stg[%0d]: got %b required %b", i, rco_stg, e.stg); end
            if (rco !== e.rco) begin errors++; $display("FAIL hold_rco[%0d]: got %b required %b", i, rco, e.rco); end
            $display("hold %0d: q=%h stg=%b rco=%b", i, q, rco_stg, rco);
        end
    endtask

    // Count to 123, clear between edges, attempt a load during clear, resume.
    task automatic test_clear_mid();
        exp_t e;
        load_n = 1'b0; enp = 1'b1; ent = 1'b1; d = 12'h120;
        @(posedge clk); #1;
        load_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back('{q: 12'h120 + 12'(i), stg: 3'b000, rco: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (q !== e.q) begin errors++; $display("FAIL clear_count_q[%0d]: got %h required %h", i, q, e.q); end
            $display("clear_mid count %0d: q=%h", i, q);
        end
        #3 clr_n = 1'b0;
        sb.push_back('{q: 12'h000, stg: 3'b000, rco: 1'b0});
        #1;
        e = sb.pop_front();
        checks += 2;
        if (q !== e.q) begin errors++; $display("FAIL clear_async_q: got %h required %h", q, e.q); end
        if (rco_stg !== e.stg) begin errors++; $display("FAIL clear_async_stg: got %b required %b", rco_stg, e.stg); end
        $display("clear_mid async clear: q=%h stg=%b", q, rco_stg);
        load_n = 1'b0; d = 12'h555;
        sb.push_back('{q: 12'h000, stg: 3'b000, rco: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (q !== e.q) begin errors++; $display("FAIL clear_load_ignored_q: got %h required %h", q, e.q); end
        $display("clear_mid load during clear: q=%h", q);
        #3 clr_n = 1'b1;
        load_n = 1'b1;
        sb.push_back('{q: 12'h001, stg: 3'b000, rco: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (q !== e.q) begin errors++; $display("FAIL clear_resume_q: got %h required %h", q, e.q); end
        $display("clear_mid resume: q=%h", q);
    endtask

    task automatic test_load_beats_count();
        exp_t e;
        load_n = 1'b0; enp = 1'b1; ent = 1'b1; d = 12'hA5C;
        sb.push_back('{q: 12'hA5C, stg: 3'b000, rco: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 3;
        if (q !== e.q) begin errors++; $display("FAIL load_beats_q: got %h required %h", q, e.q); end
        if (rco_stg !== e.stg) begin errors++; $display("FAIL load_beats_stg: got %b required %b", rco_stg, e.stg); end
        if (rco !== e.rco) begin errors++; $display("FAIL load_beats_rco: got %b required %b", rco, e.rco); end
        $display("load_beats_count: q=%h stg=%b rco=%b", q, rco_stg, rco);
        load_n = 1'b1;
    endtask

    // Single-stage wrap: F with ENT=1 carries, ENT=0 masks, next edge wraps to 0.
    task automatic test_stages1();
        exp_t e;
        row_t rows [4] = '{
            '{1'b0, 1'b1, 1'b1, 12'h00F, 1'b1, 12'h00F, 3'b001, 1'b1},
            '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h00F, 3'b000, 1'b0},
            '{1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 12'h00F, 3'b001, 1'b1},
            '{1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 12'h000, 3'b000, 1'b0}
        };
        for (int i = 0; i < 4; i++) begin
            load_n1 = rows[i].load_n; enp1 = rows[i].enp; ent1 = rows[i].ent; d1 = rows[i].d[3:0];
            sb.push_back('{q: rows[i].q, stg: rows[i].stg, rco: rows[i].rco});
            if (rows[i].edge_step) @(posedge clk);
            #1;
            e = sb.pop_front();
            checks += 3;
            if (q1 !== e.q[3:0]) begin errors++; $display("FAIL stages1_q[%0d]: got %h required %h", i, q1, e.q[3:0]); end
            if (rco_stg1 !== e.stg[0:0]) begin errors++; $display("FAIL stages1_stg[%0d]: got %b required %b", i, rco_stg1, e.stg[0]); end
            if (rco1 !== e.rco) begin errors++; $display("FAIL stages1_rco[%0d]: got %b required %b", i, rco1, e.rco); end
            $display("stages1 %0d: q=%h stg=%b rco=%b", i, q1, rco_stg1, rco1);
        end
        enp1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_count();
        test_wrap();
        test_hold();
        test_clear_mid();
        test_load_beats_count();
        test_stages1();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_74x161_cascade.md
MOD_74X161_CASCADE -- requirements
Module: mod_74x161_cascade

Interface
REQ-001 Parameter: STAGES, 3, number of cascaded 4-bit 74x161 counter stages (legal range 1..8).
REQ-002 Port: CLK  input  1  single clock; all state changes occur on its rising edge except clear.
REQ-003 Port: CLR_N  input  1  asynchronous, active-low clear of all stages.
REQ-004 Port: LOAD_N  input  1  synchronous, active-low parallel load.
REQ-005 Port: ENP  input  1  count enable P, shared by all stages.
REQ-006 Port: ENT  input  1  count enable T into stage 1; also gates RCO.
REQ-007 Port: D  input  [0:4*STAGES-1]  parallel load data; D[4*STAGES-1] is the LSB.
REQ-008 Port: Q  output  [0:4*STAGES-1]  count value; Q[4*STAGES-1] is the LSB, so the vector reads as the count.
REQ-009 Port: RCO_STG  output  [0:STAGES-1]  per-stage ripple carry; RCO_STG[STAGES-1] belongs to stage 1 (least significant nibble).
REQ-010 Port: RCO  output  1  ripple carry out of the most significant stage.
REQ-011 The design SHALL use one clock and an asynchronous, active-low reset; port names SHALL be CLK and CLR_N.

Function
REQ-012 Stage k (k=1 is the least significant nibble) SHALL hold Q[4*(STAGES-k) : 4*(STAGES-k)+3].
REQ-013 Stage 1 SHALL receive ENT from the port; stage k>1 SHALL receive as its ENT the RCO of stage k-1.
REQ-014 Stage k RCO SHALL equal (stage k ENT) AND (stage k nibble == 4'hF), purely combinational.
REQ-015 RCO SHALL equal RCO of stage STAGES; with STAGES=3 it is ENT AND Q==12'hFFF.
REQ-016 On a rising CLK edge with CLR_N=1 and LOAD_N=0, Q SHALL take D on that edge, regardless of ENP and ENT.
REQ-017 On a rising CLK edge with CLR_N=1, LOAD_N=1, ENP=1: each stage whose ENT=1 SHALL increment modulo 16; the other stages SHALL hold.
REQ-018 Net effect of REQ-017: with ENP=ENT=1, Q SHALL increment by 1 modulo 2^(4*STAGES) per edge; 12'hFFF SHALL wrap to 12'h000.
REQ-019 With LOAD_N=1 and ENP=0 or ENT=0, Q SHALL hold.
REQ-020 ENP SHALL NOT affect any RCO; ENT=0 SHALL force RCO and every RCO_STG bit to 0.
REQ-021 Latency: Q SHALL reflect a load or count on the same edge that samples it, with no pipeline stage.
REQ-022 RCO and RCO_STG SHALL follow Q and ENT combinationally in the same cycle.
REQ-023 The model SHALL be zero-delay with no #-delays in the RTL, and SHALL contain no X-generating paths when all inputs are known.

Reset
REQ-024 CLR_N=0 SHALL immediately force Q to 0, independent of CLK, LOAD_N, ENP and ENT.
REQ-025 While CLR_N=0, RCO and RCO_STG SHALL be 0 except where ENT=1 forces RCO_STG of a stage with a nibble of 4'hF; after clear every nibble is 0, so all carries are 0.
REQ-026 CLR_N=0 SHALL override a simultaneous load or count edge.
REQ-027 Counting SHALL resume on the first rising CLK edge after CLR_N returns to 1.
REQ-028 The design SHALL have no reset-release synchroniser; the bench SHALL keep CLR_N edges away from CLK edges.

Verification
REQ-029 The bench SHALL cover these directed scenarios, each checked after every edge with `FAILED on mismatch:
- CLR_N=0 at t=0, then released; ENP=ENT=1 for 3 edges -> Q=12'h000 during clear, then 12'h001, 12'h002, 12'h003.
- LOAD_N=0 with D=12'h00E, then 2 count edges -> Q=12'h00E, 12'h00F (RCO_STG stage 1 = 1), 12'h010.
- Load 12'hFFE, count -> Q=12'hFFF with RCO=1 and all RCO_STG=1; next edge gives Q=12'h000 and RCO=0.
- At Q=12'h0FF: ENT=0 -> Q holds and RCO_STG all 0; ENP=0 with ENT=1 -> Q holds and RCO_STG for stages 1 and 2 = 1.
- Count to 12'h123, then pulse CLR_N low between edges -> Q=12'h000 immediately; a LOAD_N=0 edge during clear is ignored.
- LOAD_N=0 with ENP=ENT=1 and D=12'hA5C -> Q=12'hA5C (load beats count).
REQ-030 The bench SHALL repeat the wrap scenario with STAGES=1, where Q=4'hF with ENT=1 gives RCO=1, then Q=4'h0.
